barcos_placer: RTL and testbench

- Clocked, parametrised ship-placement engine for the Battleship player board.
- Loads an initial N x N board and walks a cursor for each ship in turn, from length NUM_SHIPS down to 1.
- Supports horizontal and vertical orientation, bounds clamping and collision rejection, and writes placed ships into its own board copy.
- Sits between the button front-end and the game-control FSM, which starts it and waits for done.

---
 rtl/barcos_pkg.sv | 23 ++
 rtl/flanco_detector.sv | 18 +
 rtl/barcos_placer.sv | 192 +++++++++++++++++++
 tb/tb_barcos_placer.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/barcos_pkg.sv
// Shared types and helpers for the Battleship ship-placement engine.
package barcos_pkg;

   typedef enum logic [2:0] {IDLE, LOAD, MOVE, CHECK, WRITE, DONE} estado_t;

   localparam int CELDA_VACIA = 0;

   // Bit positions of the button/start level vector fed to the edge detectors
   localparam int B_PONER     = 0;
   localparam int B_ROTAR     = 1;
   localparam int B_ABAJO     = 2;
   localparam int B_ARRIBA    = 3;
   localparam int B_DERECHA   = 4;
   localparam int B_IZQUIERDA = 5;
   localparam int B_START     = 6;
   localparam int NUM_BTN     = 7;

   // Highest anchor coordinate on the ship axis that keeps a ship of length l on the board
   function automatic int limite_clamp(input int n, input int l);
      return n - l;
   endfunction

endpackage

// File: rtl/flanco_detector.sv
// Rising-edge detector: one-cycle pulse on the first cycle a level is seen high.
module flanco_detector (
   input  logic clk,
   input  logic rst_n,
   input  logic nivel_i,
   output logic flanco_o
);

   logic prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prev_q <= 1'b0;
      else        prev_q <= nivel_i;
   end

   assign flanco_o = nivel_i & ~prev_q;

endmodule

// File: rtl/barcos_placer.sv
// Ship-placement engine: loads a board, walks a cursor per ship, checks for
// collisions cell by cell and writes accepted ships into its working board.
module barcos_placer
   import barcos_pkg::*;
#(
   parameter int N         = 5,
   parameter int CELL_W    = 4,
   parameter int NUM_SHIPS = 5,
   parameter int XW        = $clog2(N),
   parameter int SW        = ($clog2(NUM_SHIPS + 1) > 3) ? $clog2(NUM_SHIPS + 1) : 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              izquierda,
   input  logic              derecha,
   input  logic              arriba,
   input  logic              abajo,
   input  logic              rotar,
   input  logic              poner,
   input  logic [CELL_W-1:0] matriz_in  [N][N],
   output logic [CELL_W-1:0] matriz_out [N][N],
   output logic [XW-1:0]     pos_x,
   output logic [XW-1:0]     pos_y,
   output logic              horizontal,
   output logic [SW-1:0]     ship_actual,
   output logic              busy,
   output logic              rechazo,
   output logic              done
);

   localparam logic [XW-1:0] MAX_OTRO = XW'(N - 1);

   estado_t           estado_q, estado_d;
   logic [CELL_W-1:0] matriz_q [N][N];
   logic [XW-1:0]     x_q, x_d, y_q, y_d, idx_q, idx_d;
   logic              hor_q, hor_d, coll_q, coll_d, rechazo_q, rechazo_d;
   logic [SW-1:0]     ship_q, ship_d;

   logic [NUM_BTN-1:0] nivel, flanco;
   logic [XW-1:0]      lim_eje, lim_nxt, lim_x, lim_y, ultimo, cx, cy;
   logic               ocupada, load_en, wr_en;

   assign nivel = {start, izquierda, derecha, arriba, abajo, rotar, poner};

   for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_flanco
      flanco_detector u_flanco (
         .clk      (clk),
         .rst_n    (rst_n),
         .nivel_i  (nivel[gi]),
         .flanco_o (flanco[gi])
      );
   end

   assign lim_eje = XW'(limite_clamp(N, int'(ship_q)));
   assign lim_nxt = XW'(limite_clamp(N, int'(ship_q) - 1));
   assign lim_x   = hor_q ? lim_eje : MAX_OTRO;
   assign lim_y   = hor_q ? MAX_OTRO : lim_eje;
   assign ultimo  = XW'(int'(ship_q) - 1);

   // Cell under scan/write: anchor plus idx along the ship axis
   assign cx      = hor_q ? x_q + idx_q : x_q;
   assign cy      = hor_q ? y_q : y_q + idx_q;
   assign ocupada = matriz_q[cy][cx] != CELL_W'(CELDA_VACIA);

   always_comb begin
      estado_d  = estado_q;
      x_d       = x_q;
      y_d       = y_q;
      hor_d     = hor_q;
      ship_d    = ship_q;
      idx_d     = idx_q;
      coll_d    = coll_q;
      rechazo_d = 1'b0;
      load_en   = 1'b0;
      wr_en     = 1'b0;
      unique case (estado_q)
         IDLE, DONE: begin
            if (flanco[B_START]) estado_d = LOAD;
         end
         LOAD: begin
            load_en  = 1'b1;
            ship_d   = SW'(NUM_SHIPS);
            x_d      = '0;
            y_d      = '0;
            hor_d    = 1'b1;
            estado_d = MOVE;
         end
         MOVE: begin
            if (flanco[B_PONER]) begin
               estado_d = CHECK;
               idx_d    = '0;
               coll_d   = 1'b0;
            end else if (flanco[B_ROTAR]) begin
               hor_d = ~hor_q;
               if (hor_q) begin
                  if (y_q > lim_eje) y_d = lim_eje;
               end else if (x_q > lim_eje) begin
                  x_d = lim_eje;
               end
            end else begin
               if (flanco[B_ARRIBA]) begin
                  if (y_q < lim_y) y_d = y_q + 1'b1;
               end else if (flanco[B_ABAJO] && y_q != '0) begin
                  y_d = y_q - 1'b1;
               end
               if (flanco[B_DERECHA]) begin
                  if (x_q < lim_x) x_d = x_q + 1'b1;
               end else if (flanco[B_IZQUIERDA] && x_q != '0) begin
                  x_d = x_q - 1'b1;
               end
            end
         end
         CHECK: begin
            // Always scan the full length so reject latency is fixed at L cycles
            coll_d = coll_q | ocupada;
            if (idx_q == ultimo) begin
               idx_d = '0;
               if (coll_q | ocupada) begin
                  rechazo_d = 1'b1;
                  estado_d  = MOVE;
               end else begin
                  estado_d = WRITE;
               end
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         WRITE: begin
            wr_en = 1'b1;
            if (idx_q == ultimo) begin
               idx_d  = '0;
               ship_d = ship_q - 1'b1;
               if (ship_q == SW'(1)) begin
                  estado_d = DONE;
               end else begin
                  estado_d = MOVE;
                  if (hor_q && x_q > lim_nxt)  x_d = lim_nxt;
                  if (!hor_q && y_q > lim_nxt) y_d = lim_nxt;
               end
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         default: estado_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado_q  <= IDLE;
         x_q       <= '0;
         y_q       <= '0;
         hor_q     <= 1'b1;
         ship_q    <= '0;
         idx_q     <= '0;
         coll_q    <= 1'b0;
         rechazo_q <= 1'b0;
      end else begin
         estado_q  <= estado_d;
         x_q       <= x_d;
         y_q       <= y_d;
         hor_q     <= hor_d;
         ship_q    <= ship_d;
         idx_q     <= idx_d;
         coll_q    <= coll_d;
         rechazo_q <= rechazo_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
               matriz_q[r][c] <= '0;
      end else if (load_en) begin
         matriz_q <= matriz_in;
      end else if (wr_en) begin
         matriz_q[cy][cx] <= CELL_W'(ship_q);
      end
   end

   assign matriz_out  = matriz_q;
   assign pos_x       = x_q;
   assign pos_y       = y_q;
   assign horizontal  = hor_q;
   assign ship_actual = ship_q;
   assign busy        = (estado_q != IDLE) && (estado_q != DONE);
   assign rechazo     = rechazo_q;
   assign done        = estado_q == DONE;

endmodule

// File: tb/tb_barcos_placer.sv
// Self-checking bench for barcos_placer against a press-level board model.
module tb_barcos_placer;

   localparam int N         = 5;
   localparam int CELL_W    = 4;
   localparam int NUM_SHIPS = 5;
   localparam int XW        = $clog2(N);
   localparam int SW        = 3;
   localparam int BW        = N * N * CELL_W;
   localparam int SNAPW     = 2 * XW + 1 + SW + 2 + BW;

   localparam logic [6:0] M_START = 7'b1000000;
   localparam logic [6:0] M_IZQ   = 7'b0100000;
   localparam logic [6:0] M_DER   = 7'b0010000;
   localparam logic [6:0] M_ARR   = 7'b0001000;
   localparam logic [6:0] M_ABA   = 7'b0000100;
   localparam logic [6:0] M_ROT   = 7'b0000010;
   localparam logic [6:0] M_PON   = 7'b0000001;

   logic clk = 1'b0, rst_n = 1'b1;
   logic st = 1'b0, izq = 1'b0, der = 1'b0, arr = 1'b0, aba = 1'b0, rot = 1'b0, pon = 1'b0;
   logic [CELL_W-1:0] mat_in  [N][N];
   logic [CELL_W-1:0] mat_out [N][N];
   logic [XW-1:0]     pos_x, pos_y;
   logic              horizontal, busy, rechazo, done;
   logic [SW-1:0]     ship_actual;

   int checks = 0;
   int errors = 0;

   // Model: board contents, cursor, orientation, current ship length, status
   int mb [N][N];
   int mx, my, ml;
   bit mh, mbusy, mdone;

   always #5 clk = ~clk;

   barcos_placer #(.N(N), .CELL_W(CELL_W), .NUM_SHIPS(NUM_SHIPS)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (st),
      .izquierda   (izq),
      .derecha     (der),
      .arriba      (arr),
      .abajo       (aba),
      .rotar       (rot),
      .poner       (pon),
      .matriz_in   (mat_in),
      .matriz_out  (mat_out),
      .pos_x       (pos_x),
      .pos_y       (pos_y),
      .horizontal  (horizontal),
      .ship_actual (ship_actual),
      .busy        (busy),
      .rechazo     (rechazo),
      .done        (done)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [SNAPW-1:0] dut_snap();
      logic [BW-1:0] b;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            b[(r*N+c)*CELL_W +: CELL_W] = mat_out[r][c];
      return {pos_x, pos_y, horizontal, ship_actual, busy, done, b};
   endfunction

   function automatic logic [SNAPW-1:0] mdl_snap();
      logic [BW-1:0] b;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            b[(r*N+c)*CELL_W +: CELL_W] = CELL_W'(mb[r][c]);
      return {XW'(mx), XW'(my), mh, SW'(ml), mbusy, mdone, b};
   endfunction

   function automatic int clampi(input int v, input int lo, input int hi);
      return (v < lo) ? lo : ((v > hi) ? hi : v);
   endfunction

   task automatic mdl_reset();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            mb[r][c] = 0;
      mx = 0; my = 0; ml = 0; mh = 1'b1; mbusy = 1'b0; mdone = 1'b0;
   endtask

   task automatic mdl_load();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            mb[r][c] = int'(mat_in[r][c]);
      mx = 0; my = 0; ml = NUM_SHIPS; mh = 1'b1; mbusy = 1'b1; mdone = 1'b0;
   endtask

   task automatic mdl_fit();
      if (mh) mx = clampi(mx, 0, N - ml);
      else    my = clampi(my, 0, N - ml);
   endtask

   task automatic mdl_move(input logic [6:0] m);
      int dx, dy;
      if (m[1]) begin
         mh = !mh;
         mdl_fit();
      end else begin
         dy = m[3] ? 1 : (m[2] ? -1 : 0);
         dx = m[4] ? 1 : (m[5] ? -1 : 0);
         mx = clampi(mx + dx, 0, mh ? N - ml : N - 1);
         my = clampi(my + dy, 0, mh ? N - 1 : N - ml);
      end
   endtask

   task automatic mdl_place(output bit rej);
      rej = 1'b0;
      for (int i = 0; i < ml; i++)
         if (mb[mh ? my : my + i][mh ? mx + i : mx] != 0) rej = 1'b1;
      if (!rej) begin
         for (int i = 0; i < ml; i++)
            mb[mh ? my : my + i][mh ? mx + i : mx] = ml;
         ml--;
         if (ml == 0) begin
            mbusy = 1'b0;
            mdone = 1'b1;
         end else begin
            mdl_fit();
         end
      end
   endtask

   // One press: level high for one cycle, then wait until the action has settled
   task automatic do_press(input logic [6:0] m, output bit rej);
      int len;
      @(negedge clk); {st, izq, der, arr, aba, rot, pon} = m;
      @(negedge clk); {st, izq, der, arr, aba, rot, pon} = 7'b0;
      rej = 1'b0;
      len = ml;
      if (mbusy) begin
         if (m[0]) begin
            mdl_place(rej);
            repeat (rej ? len : 2 * len) @(negedge clk);
         end else begin
            mdl_move(m);
         end
      end else if (m[6]) begin
         mdl_load();
         @(negedge clk);
      end
   endtask

   task automatic clear_board_in();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            mat_in[r][c] = '0;
   endtask

   task automatic test_reset();
      bit rej;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      mdl_reset();
      checks++;
      if (dut_snap() !== mdl_snap()) begin
         errors++; $display("FAIL reset_state: got %h expected %h", dut_snap(), mdl_snap());
      end
      checks++;
      if (rechazo !== 1'b0) begin
         errors++; $display("FAIL reset_rechazo: got %b expected 0", rechazo);
      end
      rst_n = 1'b1;
      @(negedge clk);
      do_press(M_DER, rej);
      checks++;
      if (dut_snap() !== mdl_snap()) begin
         errors++; $display("FAIL idle_ignores_move: got %h expected %h", dut_snap(), mdl_snap());
      end
      $display("test_reset done");
   endtask

   task automatic test_fill_rows();
      bit rej;
      logic [CELL_W-1:0] exp;
      int bad;
      clear_board_in();
      do_press(M_START, rej);
      checks++;
      if (dut_snap() !== mdl_snap()) begin
         errors++; $display("FAIL load: got %h expected %h", dut_snap(), mdl_snap());
      end
      for (int r = 0; r < NUM_SHIPS; r++) begin
         do_press(M_PON, rej);
         checks++;
         if (dut_snap() !== mdl_snap()) begin
            errors++; $display("FAIL place_row%0d: got %h expected %h", r, dut_snap(), mdl_snap());
         end
         if (r < NUM_SHIPS - 1) begin
            checks++;
            if (busy !== 1'b1) begin
               errors++; $display("FAIL busy_in_session row%0d: got %b expected 1", r, busy);
            end
            do_press(M_ARR, rej);
         end
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL done_after_fill: got done=%b busy=%b expected done=1 busy=0", done, busy);
      end
      for (int r = 0; r < N; r++) begin
         bad = 0;
         for (int c = 0; c < N; c++) begin
            exp = (c < NUM_SHIPS - r) ? CELL_W'(NUM_SHIPS - r) : '0;
            if (mat_out[r][c] !== exp) bad++;
         end
         checks++;
         if (bad != 0) begin
            errors++; $display("FAIL fill_row%0d: got %0d wrong cells expected 0", r, bad);
         end
      end
      $display("test_fill_rows done");
   endtask

   task automatic test_saturation();
      bit rej;
      clear_board_in();
      do_press(M_START, rej);
      do_press(M_PON, rej);
      repeat (3) do_press(M_DER, rej);
      checks++;
      if (pos_x !== XW'(1)) begin
         errors++; $display("FAIL sat_x: got %0d expected 1", pos_x);
      end
      repeat (6) do_press(M_ARR, rej);
      checks++;
      if (pos_y !== XW'(4)) begin
         errors++; $display("FAIL sat_y: got %0d expected 4", pos_y);
      end
      checks++;
      if (dut_snap() !== mdl_snap()) begin
         errors++; $display("FAIL sat_state: got %h expected %h", dut_snap(), mdl_snap());
      end
      $display("test_saturation done");
   endtask

   task automatic test_rotate_clamp();
      bit rej;
      repeat (3) do_press(M_ABA, rej);
      do_press(M_PON, rej);
      repeat (3) do_press(M_ARR, rej);
      do_press(M_DER, rej);
      do_press(M_ROT, rej);
      checks++;
      if (horizontal !== 1'b0 || pos_y !== XW'(2) || pos_x !== XW'(2)) begin
         errors++; $display("FAIL rotate_clamp: got h=%b x=%0d y=%0d expected h=0 x=2 y=2", horizontal, pos_x, pos_y);
      end
      repeat (2) do_press(M_DER, rej);
      checks++;
      if (pos_x !== XW'(4)) begin
         errors++; $display("FAIL vertical_x_limit: got %0d expected 4", pos_x);
      end
      do_press(M_PON, rej);
      checks++;
      if (mat_out[2][4] !== 4'd3 || mat_out[3][4] !== 4'd3 || mat_out[4][4] !== 4'd3) begin
         errors++; $display("FAIL vertical_write: got %0d %0d %0d expected 3 3 3", mat_out[2][4], mat_out[3][4], mat_out[4][4]);
      end
      checks++;
      if (dut_snap() !== mdl_snap()) begin
         errors++; $display("FAIL rotate_state: got %h expected %h", dut_snap(), mdl_snap());
      end
      $display("test_rotate_clamp done");
   endtask

   task automatic test_collision();
      bit rej;
      // Start during a session is ignored; then finish the session
      do_press(M_START, rej);
      checks++;
      if (dut_snap() !== mdl_snap()) begin
         errors++; $display("FAIL start_while_busy: got %h expected %h", dut_snap(), mdl_snap());
      end
      do_press(M_PON, rej);
      checks++;
      if (rej !== 1'b1 || rechazo !== 1'b1) begin
         errors++; $display("FAIL self_overlap_reject: got rechazo=%b expected 1 (model %b)", rechazo, rej);
      end
      do_press(M_IZQ, rej);
      do_press(M_PON, rej);
      do_press(M_IZQ, rej);
      do_press(M_PON, rej);
      checks++;
      if (dut_snap() !== mdl_snap() || done !== 1'b1) begin
         errors++; $display("FAIL finish_session: got %h expected %h", dut_snap(), mdl_snap());
      end
      clear_board_in();
      mat_in[0][2] = 4'd7;
      do_press(M_START, rej);
      @(negedge clk); pon = 1'b1;
      @(negedge clk); pon = 1'b0;
      for (int k = 1; k <= NUM_SHIPS + 1; k++) begin
         @(negedge clk);
         checks++;
         if (rechazo !== (k == NUM_SHIPS)) begin
            errors++; $display("FAIL rechazo_timing k=%0d: got %b expected %b", k, rechazo, k == NUM_SHIPS);
         end
      end
      mdl_place(rej);
      checks++;
      if (dut_snap() !== mdl_snap()) begin
         errors++; $display("FAIL obstacle_reject_state: got %h expected %h", dut_snap(), mdl_snap());
      end
      $display("test_collision done");
   endtask

   task automatic test_hold_and_diag();
      bit rej;
      do_press(M_ARR, rej);
      @(negedge clk); pon = 1'b1;
      repeat (20) @(negedge clk);
      pon = 1'b0;
      mdl_place(rej);
      repeat (2) @(negedge clk);
      checks++;
      if (dut_snap() !== mdl_snap()) begin
         errors++; $display("FAIL hold_poner: got %h expected %h", dut_snap(), mdl_snap());
      end
      do_press(M_DER | M_ARR, rej);
      checks++;
      if (pos_x !== XW'(1) || pos_y !== XW'(2)) begin
         errors++; $display("FAIL diagonal: got x=%0d y=%0d expected x=1 y=2", pos_x, pos_y);
      end
      $display("test_hold_and_diag done");
   endtask

   task automatic test_async_reset();
      bit rej;
      @(negedge clk); pon = 1'b1;
      @(negedge clk); pon = 1'b0;
      repeat (6) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      mdl_reset();
      checks++;
      if (dut_snap() !== mdl_snap() || rechazo !== 1'b0) begin
         errors++; $display("FAIL async_reset: got %h expected %h", dut_snap(), mdl_snap());
      end
      @(negedge clk); rst_n = 1'b1;
      repeat (3) @(negedge clk);
      do_press(M_PON, rej);
      checks++;
      if (dut_snap() !== mdl_snap()) begin
         errors++; $display("FAIL idle_after_reset: got %h expected %h", dut_snap(), mdl_snap());
      end
      do_press(M_START, rej);
      checks++;
      if (dut_snap() !== mdl_snap()) begin
         errors++; $display("FAIL restart_after_reset: got %h expected %h", dut_snap(), mdl_snap());
      end
      $display("test_async_reset done");
   endtask

   task automatic test_random();
      bit rej;
      logic [6:0] m;
      for (int s = 0; s < 6; s++) begin
         if (mbusy) begin
            @(negedge clk); rst_n = 1'b0;
            @(negedge clk); rst_n = 1'b1;
            mdl_reset();
         end
         for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
               mat_in[r][c] = ($urandom_range(0, 7) == 0) ? CELL_W'($urandom_range(1, 15)) : '0;
         do_press(M_START, rej);
         checks++;
         if (dut_snap() !== mdl_snap()) begin
            errors++; $display("FAIL rand_load s=%0d: got %h expected %h", s, dut_snap(), mdl_snap());
         end
         for (int n = 0; n < 80 && mbusy; n++) begin
            m = {($urandom_range(0, 9) == 0), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) < 3)};
            do_press(m, rej);
            checks++;
            if (dut_snap() !== mdl_snap()) begin
               errors++; $display("FAIL rand_state s=%0d n=%0d m=%b: got %h expected %h", s, n, m, dut_snap(), mdl_snap());
            end
            checks++;
            if (rechazo !== rej) begin
               errors++; $display("FAIL rand_rechazo s=%0d n=%0d: got %b expected %b", s, n, rechazo, rej);
            end
         end
         $display("random session %0d: ships left %0d", s, ml);
      end
   endtask

   initial begin
      clear_board_in();
      mdl_reset();
      test_reset();
      test_fill_rows();
      test_saturation();
      test_rotate_clamp();
      test_collision();
      test_hold_and_diag();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
